// File: rtl/seg7_count_display.sv
// Shows four 0..99 countdowns on an 8-digit multiplexed common-anode display.
// Optional build macro: LEADING_ZERO_BLANK_EN (blank a tens digit that is zero).
module seg7_count_display #(
    parameter int SCAN_DIV = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] n_count,
    input  logic [7:0] e_count,
    input  logic [7:0] s_count,
    input  logic [7:0] w_count,
    input  logic       blank,
    output logic [6:0] seg,
    output logic [7:0] an,
    output logic       upd
);

    typedef enum logic [1:0] {LOAD, SHIFT, WRITE, COMMIT} conv_state_t;

    conv_state_t state, next_state;

    logic [2:0]  shift_cnt;
    logic [1:0]  channel;
    logic [1:0]  next_channel;
    logic [7:0]  shadow  [4];
    logic [7:0]  staging [4];
    logic [7:0]  disp    [4];
    logic [7:0]  work_bin;
    logic [7:0]  work_bcd;
    logic [7:0]  bcd_adj;
    logic        load_en;
    logic        shift_en;
    logic        write_en;
    logic        commit_en;

    logic [15:0] prescale;
    logic        terminal;
    logic [2:0]  digit_idx;
    logic [7:0]  digit_byte;
    logic [3:0]  nibble;
    logic [6:0]  seg_next;

    function automatic logic [7:0] sat99(input logic [7:0] v);
        return (v > 8'd99) ? 8'd99 : v;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= LOAD;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            LOAD:    next_state = SHIFT;
            SHIFT:   next_state = (shift_cnt == 3'd7) ? WRITE : SHIFT;
            WRITE:   next_state = (channel == 2'd3) ? COMMIT : SHIFT;
            COMMIT:  next_state = LOAD;
            default: next_state = LOAD;
        endcase
    end

    always_comb begin
        load_en   = (state == LOAD);
        shift_en  = (state == SHIFT);
        write_en  = (state == WRITE);
        commit_en = (state == COMMIT);
    end

    // Shift-add-3 correction applied to both BCD nibbles before every shift.
    always_comb begin
        bcd_adj[3:0] = (work_bcd[3:0] >= 4'd5) ? work_bcd[3:0] + 4'd3 : work_bcd[3:0];
        bcd_adj[7:4] = (work_bcd[7:4] >= 4'd5) ? work_bcd[7:4] + 4'd3 : work_bcd[7:4];
        next_channel = channel + 2'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                shadow[i]  <= 8'd0;
                staging[i] <= 8'd0;
                disp[i]    <= 8'd0;
            end
            work_bin  <= 8'd0;
            work_bcd  <= 8'd0;
            shift_cnt <= 3'd0;
            channel   <= 2'd0;
            upd       <= 1'b0;
        end else begin
            upd <= commit_en;
            if (load_en) begin
                shadow[0] <= sat99(n_count);
                shadow[1] <= sat99(e_count);
                shadow[2] <= sat99(s_count);
                shadow[3] <= sat99(w_count);
                work_bin  <= sat99(n_count);
                work_bcd  <= 8'd0;
                shift_cnt <= 3'd0;
                channel   <= 2'd0;
            end
            if (shift_en) begin
                {work_bcd, work_bin} <= {bcd_adj[6:0], work_bin, 1'b0};
                shift_cnt <= shift_cnt + 3'd1;
            end
            // Preload the next channel's shadowed value while storing this one.
            if (write_en) begin
                staging[channel] <= work_bcd;
                work_bin  <= shadow[next_channel];
                work_bcd  <= 8'd0;
                shift_cnt <= 3'd0;
                if (channel != 2'd3) begin
                    channel <= next_channel;
                end
            end
            if (commit_en) begin
                for (int i = 0; i < 4; i++) begin
                    disp[i] <= staging[i];
                end
                channel <= 2'd0;
            end
        end
    end

    assign terminal = (prescale == 16'(SCAN_DIV - 1));

    always_comb begin
        digit_byte = disp[digit_idx[2:1]];
        nibble     = digit_idx[0] ? digit_byte[7:4] : digit_byte[3:0];
        seg_next   = seg_decode(nibble);
`ifdef LEADING_ZERO_BLANK_EN
        if (digit_idx[0] && (nibble == 4'd0)) begin
            seg_next = 7'h7F;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescale  <= 16'd0;
            digit_idx <= 3'd0;
            seg       <= 7'h7F;
            an        <= 8'hFF;
        end else begin
            prescale <= terminal ? 16'd0 : prescale + 16'd1;
            if (terminal) begin
                digit_idx <= digit_idx + 3'd1;
                if (blank) begin
                    an  <= 8'hFF;
                    seg <= 7'h7F;
                end else begin
                    an  <= ~(8'b1 << digit_idx);
                    seg <= seg_next;
                end
            end
        end
    end

endmodule

// File: doc/seg7_count_display.md
Name: seg7_count_display

Overview:
- Downstream consumer of the traffic-light timer FSM.
- Takes the four per-direction countdown values (n/e/s/w count, 8-bit binary) and shows them on an 8-digit, time-multiplexed, common-anode 7-segment display, two decimal digits per direction.
- Contains a sequential binary-to-BCD converter (shift-add-3) and a digit scan controller.

Parameters:
- SCAN_DIV, 1000: clock cycles each digit stays lit; legal range 2..65535.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- n_count  input  8  north countdown, binary
- e_count  input  8  east countdown, binary
- s_count  input  8  south countdown, binary
- w_count  input  8  west countdown, binary
- blank  input  1  1 = all digits off
- seg  output  7  segment drive, active-low, bit order {g,f,e,d,c,b,a}
- an  output  8  digit enables, active-low one-hot; an[i] selects digit i
- upd  output  1  one-cycle pulse when a new coherent set of four values is committed to the display

Behaviour:
- Reset (reset=0, asynchronous): all eight display digit registers = 0, staging registers = 0, converter FSM = LOAD, channel = 0, prescaler = 0, digit index = 0, seg = 7'h7F, an = 8'hFF, upd = 0.
- Converter FSM (runs continuously):
  - LOAD, 1 cycle: snapshot all four inputs into shadow registers. Any value > 99 saturates to 99.
  - SHIFT, 8 cycles per channel: double-dabble on the shadowed value for the current channel. Before each shift, add 3 to any BCD nibble >= 5.
  - WRITE, 1 cycle: store the tens and ones nibbles in staging[channel]. If channel < 3, increment channel and go to SHIFT; else go to COMMIT.
  - COMMIT, 1 cycle: copy all staging to the display registers, pulse upd=1, channel=0, go to LOAD.
  - Round length is fixed at 38 cycles: LOAD 1 + 4×(8+1) + COMMIT 1. The first upd occurs on cycle 38 after reset release.
  - Inputs changing mid-round do not affect that round; they are seen at the next LOAD. The display never shows a mix of two rounds.
- Digit map:
  - 0 = N ones, 1 = N tens, 2 = E ones, 3 = E tens, 4 = S ones, 5 = S tens, 6 = W ones, 7 = W tens.
- Scan:
  - The prescaler counts 0..SCAN_DIV-1 and wraps.
  - At terminal count: seg/an register the pattern for the current digit index, and the index increments mod 8 (7 -> 0).
  - The first digit (index 0) is lit SCAN_DIV cycles after reset release. An index-7 to index-0 wrap needs no extra cycle.
- Segment codes (active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
  - Nibble values 10..15 are unreachable; if present, seg = 7F.
- blank:
  - Sampled at each scan terminal count. While 1: an = FF, seg = 7F; scan index still advances and conversion continues.
  - Deassertion takes effect at the next terminal count.
- Reset mid-operation: any in-flight conversion is discarded. Behaviour afterwards is identical to power-up.

Optional Feature:
- LEADING_ZERO_BLANK_EN
- Defined: on a tens digit (odd index) whose nibble is 0, seg = 7F and an stays driven for timing uniformity. A count of 0 shows " 0".
- Undefined: all digits always displayed; 5 shows "05".

Test Plan:
- Reset held low with inputs 8'h25: seg=7F, an=FF, upd=0. After release: upd pulses first at cycle 38 and every 38 cycles thereafter.
- SCAN_DIV=4, n_count=37, others 0, after first upd: digit 0 shows seg=78 (7) with an=FE; digit 1 shows seg=30 (3) with an=FD.
- e_count=150 -> digits 2/3 show 9/9 (seg=10, an=FB then F7). e_count=99 gives the identical result.
- Scan order: an sequence FE, FD, FB, F7, EF, DF, BF, 7F, FE, with each value held exactly SCAN_DIV cycles.
- Change w_count 12 -> 45 at cycle 5 of a round: the next commit shows 12; the following commit shows 45; no 42/15 mixes are ever displayed.
- Assert reset mid-SHIFT, then release: outputs return to reset values immediately and upd recurs after 38 cycles. blank=1 forces an=FF at the next terminal count.
